// File: rtl/regfile_wb_ctrl.sv
// Write-port arbiter for the RV32I regfile: shares one write port between WB and a
// buffered long-latency result source, tracks pending destinations and stalls decode.
module regfile_wb_ctrl #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_rd,
  input  logic [31:0]                   wb_wd,
  input  logic                          ll_issue,
  input  logic [4:0]                    ll_issue_rd,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [4:0]                    ll_rd,
  input  logic [31:0]                   ll_wd,
  input  logic                          dec_valid,
  input  logic [4:0]                    dec_rs1,
  input  logic [4:0]                    dec_rs2,
  input  logic [4:0]                    dec_rd,
  output logic                          stall,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [31:0]                   rf_wd,
  output logic [31:0]                   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_rd_mem [FIFO_DEPTH];
  logic [31:0]   fifo_wd_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   busy_q, busy_nxt;

  logic fifo_empty, wb_take, pop, bypass, push, starve;
  logic [4:0] clr_rd;

  // Saturating increment; the counter parks at the limit until the FIFO drains.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    sat_inc = (v >= LIMIT_C) ? LIMIT_C : v + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign ll_ready   = rst_n && (count_q < DEPTH_C);
  assign wb_take    = wb_valid && (wb_rd != 5'd0);
  assign pop        = !wb_take && !fifo_empty;
  assign bypass     = !wb_take && fifo_empty && ll_valid && ll_ready;
  assign push       = ll_valid && ll_ready && !bypass;
  assign clr_rd     = pop ? fifo_rd_mem[rd_ptr] : ll_rd;
  assign starve     = (starve_cnt >= LIMIT_C);

  always_comb begin
    rf_we = 1'b0;
    rf_rd = 5'd0;
    rf_wd = 32'd0;
    if (wb_take) begin
      rf_we = 1'b1;
      rf_rd = wb_rd;
      rf_wd = wb_wd;
    end else if (pop) begin
      rf_we = (fifo_rd_mem[rd_ptr] != 5'd0);
      rf_rd = fifo_rd_mem[rd_ptr];
      rf_wd = fifo_wd_mem[rd_ptr];
    end else if (bypass) begin
      rf_we = (ll_rd != 5'd0);
      rf_rd = ll_rd;
      rf_wd = ll_wd;
    end
  end

  // Issue is applied after the clear so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (pop || bypass)
      busy_nxt[clr_rd] = 1'b0;
    if (ll_issue && (ll_issue_rd != 5'd0))
      busy_nxt[ll_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
      busy_q <= busy_nxt;
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else
        starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr] <= ll_rd;
      fifo_wd_mem[wr_ptr] <= ll_wd;
    end
  end

  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign stall      = (dec_valid && (busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd])) || starve;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: bypass, contention, full FIFO with starvation,
// x0 handling and mid-operation reset, against hand-computed expectations.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, ll_issue, ll_valid, dec_valid;
  logic [4:0]  wb_rd, ll_issue_rd, ll_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] wb_wd, ll_wd;
  logic        ll_ready, stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd, busy;
  logic [1:0]  fifo_count;

  logic [31:0] regs [32];
  int          x9_writes = 0;
  int          checks = 0;
  int          failures = 0;

  regfile_wb_ctrl #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_wd(ll_wd),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .stall(stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural regfile capturing the write port at each rising edge.
  always @(posedge clk) begin
    if (rf_we) regs[rf_rd] <= rf_wd;
    if (rf_we && rf_rd == 5'd9) x9_writes <= x9_writes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle point for combinational checks, well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_rd = 0; wb_wd = 0;
    ll_issue = 0; ll_issue_rd = 0;
    ll_valid = 0; ll_rd = 0; ll_wd = 0;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    step(); step();
    chk("ready_in_reset", {31'd0, ll_ready}, 32'd0);
    rst_n = 1;
    settle();
    chk("rst_busy", busy, 32'd0);
    chk("rst_count", {30'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, ll_ready}, 32'd1);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Bypass path
    step(); ll_issue = 1; ll_issue_rd = 5;
    step(); ll_issue = 0; dec_valid = 1; dec_rs1 = 5;
    settle();
    chk("byp_busy_set", busy, 32'h0000_0020);
    chk("byp_stall_raw", {31'd0, stall}, 32'd1);
    step(); ll_valid = 1; ll_rd = 5; ll_wd = 32'h1234;
    settle();
    chk("byp_we", {31'd0, rf_we}, 32'd1);
    chk("byp_rd", {27'd0, rf_rd}, 32'd5);
    chk("byp_wd", rf_wd, 32'h1234);
    step(); ll_valid = 0;
    settle();
    chk("byp_busy_clr", busy, 32'd0);
    chk("byp_stall_clr", {31'd0, stall}, 32'd0);
    chk("byp_count", {30'd0, fifo_count}, 32'd0);
    chk("byp_x5", regs[5], 32'h1234);

    // Contention: WB wins, result queued then drained
    step(); dec_valid = 0; dec_rs1 = 0; ll_issue = 1; ll_issue_rd = 6;
    step(); ll_issue = 0;
    wb_valid = 1; wb_rd = 3; wb_wd = 7;
    ll_valid = 1; ll_rd = 6; ll_wd = 32'hAA;
    settle();
    chk("con_wb_rd", {27'd0, rf_rd}, 32'd3);
    chk("con_wb_wd", rf_wd, 32'd7);
    step(); wb_valid = 0; ll_valid = 0;
    settle();
    chk("con_count1", {30'd0, fifo_count}, 32'd1);
    chk("con_x3", regs[3], 32'd7);
    chk("con_busy6", busy, 32'h0000_0040);
    chk("con_pop_rd", {27'd0, rf_rd}, 32'd6);
    chk("con_pop_wd", rf_wd, 32'hAA);
    step();
    settle();
    chk("con_count0", {30'd0, fifo_count}, 32'd0);
    chk("con_x6", regs[6], 32'hAA);
    chk("con_busy_clr", busy, 32'd0);

    // Full FIFO under continuous WB, starvation freeze, then in-order drain
    step(); wb_valid = 1; wb_rd = 1; wb_wd = 1; ll_valid = 1; ll_rd = 10; ll_wd = 32'h10;
    step(); wb_rd = 2; ll_rd = 11; ll_wd = 32'h11;
    settle();
    chk("full_ready_b", {31'd0, ll_ready}, 32'd1);
    step(); wb_rd = 1; ll_rd = 12; ll_wd = 32'h12;
    settle();
    chk("full_count", {30'd0, fifo_count}, 32'd2);
    chk("full_ready", {31'd0, ll_ready}, 32'd0);
    chk("starve_c", {31'd0, stall}, 32'd0);
    step(); settle(); chk("starve_d", {31'd0, stall}, 32'd0);
    step(); settle(); chk("starve_e", {31'd0, stall}, 32'd0);
    step(); settle(); chk("starve_f", {31'd0, stall}, 32'd1);
    step(); settle(); chk("starve_g", {31'd0, stall}, 32'd1);
    chk("full_count_g", {30'd0, fifo_count}, 32'd2);
    step(); wb_valid = 0;
    settle();
    chk("drain_rd10", {27'd0, rf_rd}, 32'd10);
    chk("drain_wd10", rf_wd, 32'h10);
    chk("drain_ready_full", {31'd0, ll_ready}, 32'd0);
    step();
    settle();
    chk("drain_stall_off", {31'd0, stall}, 32'd0);
    chk("drain_count1", {30'd0, fifo_count}, 32'd1);
    chk("drain_rd11", {27'd0, rf_rd}, 32'd11);
    step(); ll_valid = 0;
    settle();
    chk("pushpop_count", {30'd0, fifo_count}, 32'd1);
    chk("drain_rd12", {27'd0, rf_rd}, 32'd12);
    step();
    settle();
    chk("drain_count0", {30'd0, fifo_count}, 32'd0);
    chk("drain_x10", regs[10], 32'h10);
    chk("drain_x11", regs[11], 32'h11);
    chk("drain_x12", regs[12], 32'h12);

    // x0 handling
    step(); ll_issue = 1; ll_issue_rd = 0;
    step(); ll_issue = 0;
    settle();
    chk("x0_busy", busy, 32'd0);
    wb_valid = 1; wb_rd = 4; wb_wd = 32'h44; ll_valid = 1; ll_rd = 7; ll_wd = 32'h77;
    step(); wb_rd = 0; ll_valid = 0;
    settle();
    chk("x0_wb_count", {30'd0, fifo_count}, 32'd1);
    chk("x0_wb_we", {31'd0, rf_we}, 32'd1);
    chk("x0_wb_rd", {27'd0, rf_rd}, 32'd7);
    step(); wb_valid = 0; ll_valid = 1; ll_rd = 0; ll_wd = 32'h55;
    settle();
    chk("x0_drained", {30'd0, fifo_count}, 32'd0);
    chk("x0_drain_x7", regs[7], 32'h77);
    chk("x0_byp_we", {31'd0, rf_we}, 32'd0);
    chk("x0_byp_ready", {31'd0, ll_ready}, 32'd1);

    // Reset mid-operation
    step(); ll_issue = 1; ll_issue_rd = 9;
    wb_valid = 1; wb_rd = 1; ll_valid = 1; ll_rd = 9; ll_wd = 32'h99;
    step(); ll_issue = 0; ll_wd = 32'h98;
    step(); ll_valid = 0; wb_valid = 0; dec_valid = 1; dec_rs2 = 9;
    #1;
    chk("mid_count2", {30'd0, fifo_count}, 32'd2);
    chk("mid_busy9", busy, 32'h0000_0200);
    chk("mid_stall", {31'd0, stall}, 32'd1);
    rst_n = 0;
    #1;
    chk("mid_rst_count", {30'd0, fifo_count}, 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_ready", {31'd0, ll_ready}, 32'd0);
    step(); rst_n = 1;
    step(); step(); step();
    settle();
    chk("mid_no_x9", x9_writes, 32'd0);
    chk("mid_we_idle", {31'd0, rf_we}, 32'd0);
    chk("mid_count_post", {30'd0, fifo_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
